// File: rtl/alu_decode_stage_pkg.sv
// alu_decode_stage_pkg
// Shared definitions for the RV32I decode stage and the ALU that consumes
// its bundle: ALU_Control codes, RV32I major opcodes, operand-select
// encodings and the decoded bundle record.
// No ports (package). Optional feature macro used elsewhere:
// DECODE_ILLEGAL_TRAP_EN.

package alu_decode_stage_pkg;

   localparam int ALU_CTRL_W = 6;

   // ALU_Control codes. Branch compares reuse the ALU: BLT shares the SLT
   // code because both need a signed less-than.
   localparam logic [5:0] ALU_ADD  = 6'b000000;
   localparam logic [5:0] ALU_SUB  = 6'b001000;
   localparam logic [5:0] ALU_SLT  = 6'b000010;
   localparam logic [5:0] ALU_SLTU = 6'b000011;
   localparam logic [5:0] ALU_BLTU = 6'b010110;
   localparam logic [5:0] ALU_BGE  = 6'b010101;
   localparam logic [5:0] ALU_BGEU = 6'b010111;
   localparam logic [5:0] ALU_OR   = 6'b000110;
   localparam logic [5:0] ALU_XOR  = 6'b000100;
   localparam logic [5:0] ALU_AND  = 6'b000111;
   localparam logic [5:0] ALU_SLL  = 6'b000001;
   localparam logic [5:0] ALU_SRL  = 6'b000101;
   localparam logic [5:0] ALU_SRA  = 6'b001101;
   localparam logic [5:0] ALU_BEQ  = 6'b010000;
   localparam logic [5:0] ALU_BNE  = 6'b010001;
   localparam logic [5:0] ALU_JAL  = 6'b011111;
   localparam logic [5:0] ALU_JALR = 6'b111111;

   // RV32I major opcodes (instruction[6:0]).
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Operand selects.
   localparam logic [1:0] OP_A_RS1  = 2'b00;
   localparam logic [1:0] OP_A_PC   = 2'b01;
   localparam logic [1:0] OP_A_ZERO = 2'b10;
   localparam logic       OP_B_RS2  = 1'b0;
   localparam logic       OP_B_IMM  = 1'b1;

   // funct7 values that distinguish the alternate R-type / shift forms.
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [31:0]           imm;
      logic [1:0]            op_a_sel;
      logic                  op_b_sel;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic                  illegal;
   } decode_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// alu_decode_stage_if
// Bundles the upstream (fetch) handshake, the downstream (execute)
// handshake and the decoded bundle of the decode stage.
//   slave  : the decode stage (receives in_valid/instruction/pc_in/flush/
//            out_ready, drives in_ready/out_valid and the bundle).
//   master : the environment around it (fetch + execute).
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its payload stable until that edge, and ready
// may depend combinationally on the consumer's state.
// state is a debug view of the stage's EMPTY/FULL register.

interface alu_decode_stage_if;
   import alu_decode_stage_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           instruction;
   logic [31:0]           pc_in;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [ALU_CTRL_W-1:0] ALU_Control;
   logic [31:0]           imm;
   logic [1:0]            op_a_sel;
   logic                  op_b_sel;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [4:0]            rd;
   logic [31:0]           pc_out;
   logic                  illegal;
   logic [0:0]            state;

   modport master (
      output in_valid, instruction, pc_in, flush, out_ready,
      input  in_ready, out_valid, ALU_Control, imm, op_a_sel, op_b_sel,
             rs1, rs2, rd, pc_out, illegal, state
   );

   modport slave (
      input  in_valid, instruction, pc_in, flush, out_ready,
      output in_ready, out_valid, ALU_Control, imm, op_a_sel, op_b_sel,
             rs1, rs2, rd, pc_out, illegal, state
   );

endinterface

// File: rtl/alu_control_decoder.sv
// alu_control_decoder
// Purely combinational RV32I decoder: produces the ALU_Control code, the
// sign-extended immediate, operand selects and register indices for one
// instruction word.
// Ports:
//   instruction : in  32  RV32I instruction word
//   decoded     : out     decode_t bundle
// Parameter TRAP_EN (driven from DECODE_ILLEGAL_TRAP_EN by the parent):
//   1 -> undecodable words report illegal = 1
//   0 -> illegal stays 0 and such words decode as ADD with imm = 0
// In both cases an undecodable word yields ALU_Control = ADD, imm = 0 and
// zero operand selects, so nothing downstream sees a half-decoded bundle.

module alu_control_decoder
   import alu_decode_stage_pkg::*;
#(
   parameter bit TRAP_EN = 1'b0
) (
   input  logic [31:0] instruction,
   output decode_t     decoded
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] imm_sh;

   logic [5:0]  alu;
   logic [31:0] imm;
   logic [1:0]  a_sel;
   logic        b_sel;
   logic        bad;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];

   assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u  = {instruction[31:12], 12'b0};
   assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
   // Shift amounts are unsigned; bit 30 (arith/logical select) must not leak in.
   assign imm_sh = {27'b0, instruction[24:20]};

   always_comb begin
      alu   = ALU_ADD;
      imm   = '0;
      a_sel = OP_A_RS1;
      b_sel = OP_B_RS2;
      bad   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            imm   = imm_u;
            a_sel = OP_A_ZERO;
            b_sel = OP_B_IMM;
         end
         OPC_AUIPC: begin
            imm   = imm_u;
            a_sel = OP_A_PC;
            b_sel = OP_B_IMM;
         end
         OPC_JAL: begin
            alu   = ALU_JAL;
            imm   = imm_j;
            a_sel = OP_A_PC;
            b_sel = OP_B_IMM;
         end
         OPC_JALR: begin
            alu   = ALU_JALR;
            imm   = imm_i;
            a_sel = OP_A_PC;
            b_sel = OP_B_IMM;
            if (funct3 != 3'b000) bad = 1'b1;
         end
         OPC_BRANCH: begin
            imm = imm_b;
            case (funct3)
               3'b000:  alu = ALU_BEQ;
               3'b001:  alu = ALU_BNE;
               3'b100:  alu = ALU_SLT;
               3'b101:  alu = ALU_BGE;
               3'b110:  alu = ALU_BLTU;
               3'b111:  alu = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            imm   = imm_i;
            b_sel = OP_B_IMM;
            case (funct3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
               default:                                bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            imm   = imm_s;
            b_sel = OP_B_IMM;
            case (funct3)
               3'b000, 3'b001, 3'b010: bad = 1'b0;
               default:                bad = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            imm   = imm_i;
            b_sel = OP_B_IMM;
            case (funct3)
               3'b000: alu = ALU_ADD;
               3'b010: alu = ALU_SLT;
               3'b011: alu = ALU_SLTU;
               3'b100: alu = ALU_XOR;
               3'b110: alu = ALU_OR;
               3'b111: alu = ALU_AND;
               3'b001: begin
                  imm = imm_sh;
                  if (funct7 == F7_BASE) alu = ALU_SLL;
                  else                   bad = 1'b1;
               end
               default: begin
                  imm = imm_sh;
                  if (funct7 == F7_BASE)     alu = ALU_SRL;
                  else if (funct7 == F7_ALT) alu = ALU_SRA;
                  else                       bad = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            case ({funct7, funct3})
               {F7_BASE, 3'b000}: alu = ALU_ADD;
               {F7_ALT,  3'b000}: alu = ALU_SUB;
               {F7_BASE, 3'b001}: alu = ALU_SLL;
               {F7_BASE, 3'b010}: alu = ALU_SLT;
               {F7_BASE, 3'b011}: alu = ALU_SLTU;
               {F7_BASE, 3'b100}: alu = ALU_XOR;
               {F7_BASE, 3'b101}: alu = ALU_SRL;
               {F7_ALT,  3'b101}: alu = ALU_SRA;
               {F7_BASE, 3'b110}: alu = ALU_OR;
               {F7_BASE, 3'b111}: alu = ALU_AND;
               default:           bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
   end

   always_comb begin
      decoded     = '0;
      decoded.rs1 = instruction[19:15];
      decoded.rs2 = instruction[24:20];
      decoded.rd  = instruction[11:7];
      if (!bad) begin
         decoded.alu_ctrl = alu;
         decoded.imm      = imm;
         decoded.op_a_sel = a_sel;
         decoded.op_b_sel = b_sel;
      end
      decoded.illegal = bad && TRAP_EN;
   end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// One-entry pipeline register between fetch and execute that decodes an
// RV32I instruction and presents the ALU bundle with a valid/ready
// handshake. Two states: EMPTY and FULL (FULL == out_valid).
// Ports:
//   clock : in   sole clock, rising edge
//   reset : in   asynchronous, active-high; empties the stage immediately
//   bus   : alu_decode_stage_if.slave (handshakes, decoded bundle, state)
// Optional feature: DECODE_ILLEGAL_TRAP_EN -- when defined, undecodable
// instructions are held with illegal = 1; otherwise illegal is always 0
// and they pass through as ADD with imm = 0.

module alu_decode_stage
   import alu_decode_stage_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   alu_decode_stage_if.slave bus
);

`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]  state_q;
   decode_t     bundle_q;
   logic [31:0] pc_q;
   decode_t     dec;
   logic        full;
   logic        ready;
   logic        accept;
   logic        consume;

   alu_control_decoder #(
      .TRAP_EN (TRAP_EN)
   ) u_decoder (
      .instruction (bus.instruction),
      .decoded     (dec)
   );

   assign full    = (state_q == ST_FULL);
   // Ready whenever the slot is free or is being emptied this cycle, which
   // gives back-to-back transfers with no bubble.
   assign ready   = !full || bus.out_ready;
   assign accept  = bus.in_valid && ready;
   assign consume = full && bus.out_ready;

   // Priority: reset, then flush, then accept (which also covers a
   // simultaneous consume), then a consume alone.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_EMPTY;
         bundle_q <= '0;
         pc_q     <= '0;
      end else if (bus.flush) begin
         state_q  <= ST_EMPTY;
      end else if (accept) begin
         state_q  <= ST_FULL;
         bundle_q <= dec;
         pc_q     <= bus.pc_in;
      end else if (consume) begin
         state_q  <= ST_EMPTY;
      end
   end

   assign bus.in_ready    = ready;
   assign bus.out_valid   = full;
   assign bus.state       = state_q;
   assign bus.ALU_Control = bundle_q.alu_ctrl;
   assign bus.imm         = bundle_q.imm;
   assign bus.op_a_sel    = bundle_q.op_a_sel;
   assign bus.op_b_sel    = bundle_q.op_b_sel;
   assign bus.rs1         = bundle_q.rs1;
   assign bus.rs2         = bundle_q.rs2;
   assign bus.rd          = bundle_q.rd;
   assign bus.pc_out      = pc_q;
   assign bus.illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
// Directed bench for alu_decode_stage: a table of instruction vectors with
// hand-computed bundles applied back-to-back, then hand-written sequences
// for stall, flush and asynchronous reset.

module tb_alu_decode_stage;

   logic clock = 1'b0;
   logic reset;

   alu_decode_stage_if bus ();

   alu_decode_stage dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] instr;
      logic [5:0]  alu;
      logic [31:0] imm;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  chk;   // [2] rd, [1] rs1, [0] rs2 are meaningful
      logic        bad;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {im, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
      return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
   endfunction

   task automatic add_vec(input logic [31:0] instr, input logic [5:0] alu,
                          input logic [31:0] imm, input logic [1:0] a_sel,
                          input logic b_sel, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] chk, input logic bad);
      vec_t v;
      v.instr = instr; v.alu = alu; v.imm = imm; v.a_sel = a_sel; v.b_sel = b_sel;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.chk = chk; v.bad = bad;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid    = v;
      bus.instruction = instr;
      bus.pc_in       = pc;
      bus.out_ready   = ordy;
      bus.flush       = fl;
   endtask

   logic [31:0] i_sub, i_xor, i_and, i_or, i_sltu;

   initial begin
      i_sub  = enc_r(7'h20, 5'd5, 5'd4, 3'b000, 5'd3, 7'b0110011);
      i_xor  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011);
      i_and  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011);
      i_or   = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011);
      i_sltu = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011);

      //       instr                                         alu        imm           a      b     rd     rs1    rs2    chk     bad
      add_vec(32'hFFB10093,                                 6'b000000, 32'hFFFFFFFB, 2'b00, 1'b1, 5'd1,  5'd2,  5'd0,  3'b110, 1'b0); // ADDI x1,x2,-5
      add_vec(i_sub,                                        6'b001000, 32'h0,        2'b00, 1'b0, 5'd3,  5'd4,  5'd5,  3'b111, 1'b0); // SUB
      add_vec(enc_b(13'h1FF8, 5'd7, 5'd6, 3'b111),          6'b010111, 32'hFFFFFFF8, 2'b00, 1'b0, 5'd0,  5'd6,  5'd7,  3'b011, 1'b0); // BGEU -8
      add_vec(enc_u(20'h12345, 5'd10, 7'b0110111),          6'b000000, 32'h12345000, 2'b10, 1'b1, 5'd10, 5'd0,  5'd0,  3'b100, 1'b0); // LUI
      add_vec(enc_u(20'hFFFFF, 5'd5, 7'b0010111),           6'b000000, 32'hFFFFF000, 2'b01, 1'b1, 5'd5,  5'd0,  5'd0,  3'b100, 1'b0); // AUIPC
      add_vec(enc_s(12'h804, 5'd9, 5'd8, 3'b010),           6'b000000, 32'hFFFFF804, 2'b00, 1'b1, 5'd0,  5'd8,  5'd9,  3'b011, 1'b0); // SW
      add_vec(enc_i(12'h010, 5'd8, 3'b010, 5'd11, 7'b0000011), 6'b000000, 32'h00000010, 2'b00, 1'b1, 5'd11, 5'd8, 5'd0, 3'b110, 1'b0); // LW
      add_vec(enc_j(21'h000800, 5'd1),                      6'b011111, 32'h00000800, 2'b01, 1'b1, 5'd1,  5'd0,  5'd0,  3'b100, 1'b0); // JAL
      add_vec(enc_i(12'hFFC, 5'd1, 3'b000, 5'd0, 7'b1100111), 6'b111111, 32'hFFFFFFFC, 2'b01, 1'b1, 5'd0, 5'd1, 5'd0, 3'b110, 1'b0); // JALR
      add_vec(enc_i({7'h20, 5'd7}, 5'd3, 3'b101, 5'd4, 7'b0010011), 6'b001101, 32'd7, 2'b00, 1'b1, 5'd4, 5'd3, 5'd0, 3'b110, 1'b0); // SRAI
      add_vec(enc_i({7'h00, 5'd31}, 5'd3, 3'b001, 5'd4, 7'b0010011), 6'b000001, 32'd31, 2'b00, 1'b1, 5'd4, 5'd3, 5'd0, 3'b110, 1'b0); // SLLI
      add_vec(enc_i(12'hFFF, 5'd2, 3'b011, 5'd5, 7'b0010011), 6'b000011, 32'hFFFFFFFF, 2'b00, 1'b1, 5'd5, 5'd2, 5'd0, 3'b110, 1'b0); // SLTIU
      add_vec(i_xor,                                        6'b000100, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // XOR
      add_vec(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011), 6'b001101, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // SRA
      add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011), 6'b000101, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // SRL
      add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011), 6'b000001, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // SLL
      add_vec(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011), 6'b000010, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // SLT
      add_vec(i_sltu,                                       6'b000011, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // SLTU
      add_vec(i_or,                                         6'b000110, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // OR
      add_vec(i_and,                                        6'b000111, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b0); // AND
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b000),          6'b010000, 32'd16, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b0); // BEQ
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b001),          6'b010001, 32'd16, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b0); // BNE
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b100),          6'b000010, 32'd16, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b0); // BLT
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b101),          6'b010101, 32'd16, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b0); // BGE
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b110),          6'b010110, 32'd16, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b0); // BLTU
      add_vec(32'hFFFFFFFF,                                 6'b000000, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1); // bad opcode
      add_vec(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), 6'b000000, 32'h0, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 3'b111, 1'b1); // bad funct7
      add_vec(enc_b(13'h0010, 5'd2, 5'd1, 3'b010),          6'b000000, 32'h0, 2'b00, 1'b0, 5'd0, 5'd1, 5'd2, 3'b011, 1'b1); // bad branch funct3

      // Clock/reset
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset alu", 32'(bus.ALU_Control), 32'd0);
      check("reset imm", bus.imm, 32'd0);
      check("reset sel", 32'({bus.op_a_sel, bus.op_b_sel}), 32'd0);
      check("reset regs", 32'({bus.rs1, bus.rs2, bus.rd}), 32'd0);
      check("reset pc_out", bus.pc_out, 32'd0);
      check("reset illegal", 32'(bus.illegal), 32'd0);
      reset = 1'b0;
      #1;
      check("idle in_ready", 32'(bus.in_ready), 32'd1);

      // Table: back-to-back accepts with out_ready held high.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
         #1;
         check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
         next_cycle();
         check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("v%0d alu", i), 32'(bus.ALU_Control), 32'(vecs[i].alu));
         check($sformatf("v%0d imm", i), bus.imm, vecs[i].imm);
         check($sformatf("v%0d op_a_sel", i), 32'(bus.op_a_sel), 32'(vecs[i].a_sel));
         check($sformatf("v%0d op_b_sel", i), 32'(bus.op_b_sel), 32'(vecs[i].b_sel));
         check($sformatf("v%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].bad & TRAP_EN));
         check($sformatf("v%0d pc_out", i), bus.pc_out, 32'h1000 + 32'(i * 4));
         if (vecs[i].chk[2]) check($sformatf("v%0d rd", i), 32'(bus.rd), 32'(vecs[i].rd));
         if (vecs[i].chk[1]) check($sformatf("v%0d rs1", i), 32'(bus.rs1), 32'(vecs[i].rs1));
         if (vecs[i].chk[0]) check($sformatf("v%0d rs2", i), 32'(bus.rs2), 32'(vecs[i].rs2));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      next_cycle();
      check("drain out_valid", 32'(bus.out_valid), 32'd0);

      // Stall: FULL, out_ready low for 3 cycles with a pending instruction.
      drive(1'b1, i_sub, 32'h2000, 1'b1, 1'b0);
      next_cycle();
      check("stall load valid", 32'(bus.out_valid), 32'd1);
      drive(1'b1, i_xor, 32'h2004, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d in_ready", c), 32'(bus.in_ready), 32'd0);
         next_cycle();
         check($sformatf("stall%0d valid", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("stall%0d alu", c), 32'(bus.ALU_Control), 32'b001000);
         check($sformatf("stall%0d pc_out", c), bus.pc_out, 32'h2000);
         check($sformatf("stall%0d rs2", c), 32'(bus.rs2), 32'd5);
      end
      bus.out_ready = 1'b1;
      #1;
      check("unstall in_ready", 32'(bus.in_ready), 32'd1);
      next_cycle();
      check("unstall valid", 32'(bus.out_valid), 32'd1);
      check("unstall alu", 32'(bus.ALU_Control), 32'b000100);
      check("unstall pc_out", bus.pc_out, 32'h2004);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      next_cycle();
      check("unstall drain", 32'(bus.out_valid), 32'd0);

      // Flush while FULL with a new instruction offered.
      drive(1'b1, i_and, 32'h3000, 1'b0, 1'b0);
      next_cycle();
      check("flush pre valid", 32'(bus.out_valid), 32'd1);
      check("flush pre alu", 32'(bus.ALU_Control), 32'b000111);
      drive(1'b1, i_or, 32'h3004, 1'b0, 1'b1);
      next_cycle();
      check("flush valid", 32'(bus.out_valid), 32'd0);
      check("flush state", 32'(bus.state), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      repeat (2) begin
         next_cycle();
         check("flush dropped", 32'(bus.out_valid), 32'd0);
      end

      // Asynchronous reset mid-cycle while FULL.
      drive(1'b1, i_sltu, 32'h4000, 1'b0, 1'b0);
      next_cycle();
      check("areset pre valid", 32'(bus.out_valid), 32'd1);
      check("areset pre pc", bus.pc_out, 32'h4000);
      bus.in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("areset valid", 32'(bus.out_valid), 32'd0);
      check("areset alu", 32'(bus.ALU_Control), 32'd0);
      check("areset pc_out", bus.pc_out, 32'd0);
      check("areset rd", 32'(bus.rd), 32'd0);
      #1;
      reset = 1'b0;
      next_cycle();
      check("areset post valid", 32'(bus.out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: in_valid  input  1  the upstream fetch presents an instruction.
REQ-004 SHALL: in_ready  output  1  the stage accepts the instruction this cycle.
REQ-005 SHALL: instruction  input  32  RV32I instruction word.
REQ-006 SHALL: pc_in  input  32  address of the instruction.
REQ-007 SHALL: flush  input  1  discard the held and incoming instructions.
REQ-008 SHALL: out_valid  output  1  the decoded bundle is valid.
REQ-009 SHALL: out_ready  input  1  the execute stage consumes the bundle.
REQ-010 SHALL: ALU_Control  output  6  ALU operation code.
REQ-011 SHALL: imm  output  32  sign-extended immediate.
REQ-012 SHALL: op_a_sel  output  2  operand A source: 00 = rs1, 01 = pc, 10 = zero.
REQ-013 SHALL: op_b_sel  output  1  operand B source: 0 = rs2, 1 = imm.
REQ-014 SHALL: rs1, rs2, rd  output  5 each  register indices.
REQ-015 SHALL: pc_out  output  32  registered copy of pc_in.
REQ-016 SHALL: illegal  output  1  the held instruction is not decodable.

Function
REQ-017 SHALL: the stage is one pipeline register with two states, EMPTY and FULL, and FULL is exactly equivalent to out_valid = 1.
REQ-018 SHALL: in_ready = !out_valid || out_ready, combinationally.
REQ-019 SHALL: on in_valid && in_ready, the decoded bundle is registered and the state becomes FULL on the next edge (latency 1 cycle).
REQ-020 SHALL: on out_ready && out_valid && !in_valid, the state becomes EMPTY.
REQ-021 SHALL: a consume and an accept in the same cycle keep the state FULL with the new bundle, giving full throughput with no bubble.
REQ-022 SHALL: while FULL && !out_ready, every output holds stable.
REQ-023 SHALL: flush has priority over all other events; on the next edge the state is EMPTY and the incoming instruction is dropped.
REQ-024 SHALL: the ALU_Control encoding is:
- ADD 000000 for LUI, AUIPC, loads, stores, ADDI, ADD
- SUB 001000
- SLT/SLTI/BLT 000010
- SLTU/SLTIU 000011
- BLTU 010110
- BGE 010101
- BGEU 010111
- OR 000110, XOR 000100, AND 000111
- SLL 000001, SRL 000101, SRA 001101
- BEQ 010000, BNE 010001
- JAL 011111, JALR 111111
REQ-025 SHALL: immediates are decoded per the I, S, B, U and J formats with sign extension from bit 31; the R format gives imm = 0.
REQ-026 SHALL: operand selection is LUI: op_a_sel = 10, op_b_sel = 1; AUIPC: op_a_sel = 01, op_b_sel = 1; JAL/JALR: op_a_sel = 01; branches: op_a_sel = 00, op_b_sel = 0.
REQ-027 SHALL: shift-immediates use imm = {27'b0, instruction[24:20]}.
REQ-028 SHALL: an unknown opcode, or an unknown funct3/funct7 combination, sets illegal = 1 with ALU_Control = 000000.

Reset
REQ-029 SHALL: reset forces the state to EMPTY, with out_valid = 0, ALU_Control = 0, imm = 0, selects = 0, register indices = 0, pc_out = 0 and illegal = 0.
REQ-030 SHALL: a reset asserted mid-handshake discards the held bundle immediately, without waiting for a clock edge.

Configuration
REQ-031 SHALL: when DECODE_ILLEGAL_TRAP_EN is defined, an illegal instruction is held FULL with illegal = 1 and is never auto-dropped.
REQ-032 SHALL: when DECODE_ILLEGAL_TRAP_EN is not defined, illegal is tied to 0 and an undecodable instruction passes through as ADD with imm = 0.

Structure
REQ-033 SHALL: the ALU_Control codes, opcode constants and op-select encodings live in a shared package that the ALU also uses.
REQ-034 SHALL: decoding is performed by a combinational sub-module, alu_control_decoder, with the handshake register in the parent module.

Verification
REQ-035 SHALL: ADDI x1, x2, -5 (0xFFB10093) accepted -> one cycle later out_valid = 1, ALU_Control = 000000, imm = 0xFFFFFFFB, op_b_sel = 1, rd = 1.
REQ-036 SHALL: back-to-back SUB then BGEU with out_ready = 1 every cycle -> consecutive bundles 001000 then 010111, with in_ready held at 1 throughout.
REQ-037 SHALL: FULL with out_ready = 0 for 3 cycles while in_valid = 1 -> in_ready = 0 and outputs unchanged; when out_ready rises, the next instruction appears on the following cycle.
REQ-038 SHALL: flush asserted while FULL and in_valid = 1 -> next cycle out_valid = 0 and the incoming instruction is never presented.
REQ-039 SHALL: instruction 0xFFFFFFFF with DECODE_ILLEGAL_TRAP_EN defined -> illegal = 1, ALU_Control = 000000; without the macro -> illegal = 0.
REQ-040 SHALL: reset pulsed asynchronously mid-cycle while FULL -> out_valid = 0 before the next clock edge.
